multi_cycle_alu: RTL and testbench
==================================

MULTI_CYCLE_ALU -- requirements
Module: multi_cycle_alu

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; all state SHALL update on the rising edge of clk only.
REQ-002 The ports SHALL be as follows, one per line:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset, sampled on the clk rising edge
- start  input  1  request; sampled only in IDLE
- Op  input  4  operation code produced by ALUControl
- A  input  32  operand A (rs)
- B  input  32  operand B (rt/imm); the shifted operand for sll
- ShiftCount  input  5  shift amount for sll
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle completion pulse
- Result  output  32  registered result
- Zero  output  1  high when the registered Result is zero
- Overflow  output  1  signed overflow, add/sub only
- Illegal  output  1  the completed Op was unsupported

Function
REQ-003 The Op encoding SHALL be: 0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt, 1100 nor, 1110 sll; every other code SHALL be illegal.
REQ-004 The FSM SHALL have exactly four states, IDLE, EXEC, SHIFT and DONE, and SHALL reset to IDLE.
REQ-005 In IDLE with start=1, the block SHALL latch Op, A, B and ShiftCount into internal registers and go to EXEC; in IDLE with start=0 it SHALL stay in IDLE.
REQ-006 A start asserted in any state other than IDLE SHALL be ignored and SHALL NOT be queued, and changes to the operand inputs after the latch edge SHALL NOT affect the operation in progress.
REQ-007 In EXEC with latched Op=1110 and latched ShiftCount not equal to 0, the block SHALL load its shift register with latched B, load its counter with ShiftCount, and go to SHIFT.
REQ-008 In EXEC for any other case, the block SHALL write Result, Zero, Overflow and Illegal on that edge and go to DONE.
REQ-009 In SHIFT, the shift register SHALL shift left by one bit per cycle with zero fill, and the counter SHALL decrement by one per cycle.
REQ-010 On the SHIFT edge where the counter equals 1, the final shifted value SHALL be written to Result and the state SHALL go to DONE.
REQ-011 In DONE, done SHALL be 1, and the next state SHALL be IDLE unconditionally.
REQ-012 Latency SHALL be measured from the edge that samples start to the first cycle with done=1: 2 cycles for all non-shift Ops and for sll with ShiftCount=0, and 2+ShiftCount cycles for sll with ShiftCount from 1 to 31.
REQ-013 add and sub SHALL use modulo-2^32 arithmetic.
REQ-014 Overflow SHALL be 1 only when the operands have the required signs and the sign of the result differs: same-sign operands for add, opposite-sign operands for sub; Overflow SHALL be 0 for all other Ops.
REQ-015 slt SHALL perform a signed comparison and SHALL produce 32'd1 when A is less than B and 32'd0 otherwise.
REQ-016 nor SHALL produce the bitwise inverse of (A or B).
REQ-017 sll with ShiftCount=0 SHALL produce Result equal to B.
REQ-018 An illegal Op SHALL produce Result=0, Zero=1, Overflow=0 and Illegal=1, and SHALL have the normal 2-cycle latency.
REQ-019 Zero SHALL equal the reduction NOR of the value written to Result on the same edge.
REQ-020 Result, Zero, Overflow and Illegal SHALL hold their values until the next operation completes; they SHALL NOT change in IDLE, EXEC or SHIFT.
REQ-021 done SHALL be high for exactly one cycle per accepted start, and done and busy SHALL both be high in DONE.

Reset
REQ-022 When rst_n=0 at a rising edge, the following SHALL hold after that edge:
- state = IDLE
- busy = 0, done = 0
- Result = 0, Zero = 1, Overflow = 0, Illegal = 0
- shift register and counter cleared
REQ-023 A reset asserted during EXEC, SHIFT or DONE SHALL abort the operation with no done pulse, and no result SHALL be written afterwards.
REQ-024 A start sampled on the same edge as rst_n=0 SHALL be dropped.

Verification
REQ-025 The bench SHALL cover: add, A=32'h7FFFFFFF, B=1 -> done 2 cycles after start; Result=32'h80000000; Overflow=1; Zero=0.
REQ-026 The bench SHALL cover: sub, A=5, B=5 -> Result=0; Zero=1; Overflow=0. Then slt, A=32'hFFFFFFFF, B=1 -> Result=1.
REQ-027 The bench SHALL cover: sll, B=32'h00000003, ShiftCount=4 -> busy for 5 cycles; done 6 cycles after start; Result=32'h00000030.
REQ-028 The bench SHALL cover: sll, ShiftCount=0, B=32'hA5A5A5A5 -> done after 2 cycles; Result=32'hA5A5A5A5.
REQ-029 The bench SHALL cover: Op=4'b1010 -> Result=0; Illegal=1; Zero=1. The next legal op (and, A=32'hF0F0F0F0, B=32'hFF00FF00) -> Result=32'hF000F000; Illegal=0.
REQ-030 The bench SHALL cover: sll with ShiftCount=20, with start re-pulsed during SHIFT -> the extra start is ignored and exactly one done pulse occurs. A second run with rst_n=0 in the 3rd SHIFT cycle -> no done pulse; all outputs return to reset values; a start after reset is accepted normally.

Source files
------------

// File: rtl/multi_cycle_alu.sv
// -----------------------------------------------------------------------------
// multi_cycle_alu
//
// This is a small ALU that takes several clock cycles per operation. It
// supports and, or, add, sub, slt and nor, and each of these finishes in two
// cycles. It also supports sll, which is done with a bit-serial shifter that
// moves the value left by one bit per cycle.
//
// A four-state FSM (IDLE, EXEC, SHIFT, DONE) controls the block. The operands
// are captured when start is accepted, so later changes on the inputs do not
// affect the operation in progress. The result and flag outputs are registered
// and keep their value until the next operation completes.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   start       operation request, only looked at in IDLE
//   Op          4-bit operation code (ALUControl encoding)
//   A, B        32-bit operands; B is the value shifted by sll
//   ShiftCount  5-bit shift amount for sll
//   busy        high in every state except IDLE
//   done        one-cycle completion pulse (DONE state)
//   Result      registered 32-bit result
//   Zero        high when Result is zero
//   Overflow    signed overflow of add/sub
//   Illegal     the completed Op was not a supported code
// -----------------------------------------------------------------------------
module multi_cycle_alu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [4:0]  ShiftCount,
    output logic        busy,
    output logic        done,
    output logic [31:0] Result,
    output logic        Zero,
    output logic        Overflow,
    output logic        Illegal
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_SLL = 4'b1110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;

    // Operands captured when start is accepted.
    logic [3:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [4:0]  sc_q;

    // Bit-serial shifter: the working value and the number of shifts still to do.
    logic [31:0] shift_q;
    logic [4:0]  count_q;

    logic [31:0] shifted;
    logic [31:0] sum;
    logic [31:0] diff;
    logic [31:0] alu_result;
    logic        alu_ovf;
    logic        alu_illegal;

    assign shifted = {shift_q[30:0], 1'b0};
    assign sum     = a_q + b_q;
    assign diff    = a_q - b_q;

    // Result of every single-step operation. sll only goes through this path
    // when ShiftCount is zero, and in that case the result is just B.
    always_comb begin
        // NOTE: every output of this block gets a default value first. This
        // way no path leaves a signal unassigned, so no latch is inferred.
        alu_result  = '0;
        alu_ovf     = 1'b0;
        alu_illegal = 1'b0;
        unique case (op_q)
            OP_AND: alu_result = a_q & b_q;
            OP_OR:  alu_result = a_q | b_q;
            OP_ADD: begin
                alu_result = sum;
                // Operands have the same sign, but the sum has a different sign.
                alu_ovf    = (a_q[31] == b_q[31]) && (sum[31] != a_q[31]);
            end
            OP_SUB: begin
                alu_result = diff;
                // Operands have different signs, and the result takes the sign of B.
                alu_ovf    = (a_q[31] != b_q[31]) && (diff[31] != a_q[31]);
            end
            OP_SLT: alu_result = ($signed(a_q) < $signed(b_q)) ? 32'd1 : 32'd0;
            OP_NOR: alu_result = ~(a_q | b_q);
            OP_SLL: alu_result = b_q;
            default: alu_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the operand and shifter registers are also cleared on reset.
            // A reset in the middle of an operation then leaves nothing behind
            // that could be written to Result later.
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            Result   <= '0;
            Zero     <= 1'b1;
            Overflow <= 1'b0;
            Illegal  <= 1'b0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sc_q     <= '0;
            shift_q  <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: all state here uses non-blocking assignment. Every register
            // then sees the values from before the edge, no matter in which
            // order the statements are written.
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= Op;
                        a_q   <= A;
                        b_q   <= B;
                        sc_q  <= ShiftCount;
                        busy  <= 1'b1;
                        state <= EXEC;
                    end
                end

                EXEC: begin
                    if (op_q == OP_SLL && sc_q != 5'd0) begin
                        shift_q <= b_q;
                        count_q <= sc_q;
                        state   <= SHIFT;
                    end else begin
                        Result   <= alu_result;
                        Zero     <= ~|alu_result;
                        Overflow <= alu_ovf;
                        Illegal  <= alu_illegal;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end

                SHIFT: begin
                    shift_q <= shifted;
                    count_q <= count_q - 5'd1;
                    // The last shift happens on this edge, so the shifted value
                    // goes straight to Result.
                    if (count_q == 5'd1) begin
                        Result   <= shifted;
                        Zero     <= ~|shifted;
                        Overflow <= 1'b0;
                        Illegal  <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_alu.sv
// -----------------------------------------------------------------------------
// tb_multi_cycle_alu
//
// This is a self-checking bench for multi_cycle_alu.
//
// A behavioural model predicts busy, done and the registered outputs on every
// cycle. It works at the transaction level: the expected result comes from
// plain arithmetic, and the expected latency is 2 or 2+ShiftCount. A compare
// process checks the DUT against the model on each falling edge.
//
// Directed operations also check hand-computed literal results, flags and
// latencies.
// -----------------------------------------------------------------------------
module tb_multi_cycle_alu;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  ShiftCount;
    logic        busy;
    logic        done;
    logic [31:0] Result;
    logic        Zero;
    logic        Overflow;
    logic        Illegal;

    int tests = 0;
    int fails = 0;

    multi_cycle_alu dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .Op         (Op),
        .A          (A),
        .B          (B),
        .ShiftCount (ShiftCount),
        .busy       (busy),
        .done       (done),
        .Result     (Result),
        .Zero       (Zero),
        .Overflow   (Overflow),
        .Illegal    (Illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        ill;
        int          lat;
    } exp_t;

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] sc);
        exp_t   e;
        longint sa;
        longint sb;
        longint wide;
        sa    = $signed(a);
        sb    = $signed(b);
        e.res = 32'd0;
        e.ovf = 1'b0;
        e.ill = 1'b0;
        e.lat = 2;
        case (op)
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b0010: begin
                wide  = sa + sb;
                e.res = a + b;
                e.ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            4'b0110: begin
                wide  = sa - sb;
                e.res = a - b;
                e.ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            4'b0111: e.res = (sa < sb) ? 32'd1 : 32'd0;
            4'b1100: e.res = ~(a | b);
            4'b1110: begin
                e.res = b << sc;
                e.lat = 2 + int'(sc);
            end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    int          m_left = 0;
    exp_t        pending;
    logic [31:0] m_res  = 32'd0;
    logic        m_zero = 1'b1;
    logic        m_ovf  = 1'b0;
    logic        m_ill  = 1'b0;
    logic        chk_en = 1'b0;

    // m_left counts the edges still to go before the DONE cycle.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_left <= 0;
            m_res  <= 32'd0;
            m_zero <= 1'b1;
            m_ovf  <= 1'b0;
            m_ill  <= 1'b0;
        end else if (!m_busy) begin
            if (start) begin
                pending <= model(Op, A, B, ShiftCount);
                m_left  <= model(Op, A, B, ShiftCount).lat - 1;
                m_busy  <= 1'b1;
            end
        end else if (m_done) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
        end else begin
            if (m_left == 1) begin
                m_done <= 1'b1;
                m_res  <= pending.res;
                m_zero <= (pending.res == 32'd0);
                m_ovf  <= pending.ovf;
                m_ill  <= pending.ill;
            end
            m_left <= m_left - 1;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en)
            check("cycle", {27'd0, busy, done, Zero, Overflow, Illegal, Result},
                  {27'd0, m_busy, m_done, m_zero, m_ovf, m_ill, m_res});
    end

    // ---------------- stimulus helpers ----------------
    task automatic garble();
        Op         = 4'($urandom);
        A          = $urandom;
        B          = $urandom;
        ShiftCount = 5'($urandom);
    endtask

    task automatic do_op(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sc,
                         input logic [31:0] e_res, input logic e_zero, input logic e_ovf,
                         input logic e_ill, input int e_lat, output int busy_only);
        int n;
        @(negedge clk);
        start = 1'b1; Op = op; A = a; B = b; ShiftCount = sc;
        @(negedge clk);
        start = 1'b0;
        garble();
        n = 1;
        busy_only = 0;
        while (!done && n < 100) begin
            if (busy) busy_only++;
            @(negedge clk);
            n++;
        end
        check({name, "_lat"}, 64'(n), 64'(e_lat));
        check({name, "_res"}, {32'd0, Result}, {32'd0, e_res});
        check({name, "_flags"}, {61'd0, Zero, Overflow, Illegal}, {61'd0, e_zero, e_ovf, e_ill});
        @(negedge clk);
    endtask

    task automatic count_done(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int bc;
        int pulses;
        rst_n = 1'b0;
        start = 1'b1;              // start held high during reset must be dropped
        Op = 4'b0010; A = 32'd1; B = 32'd1; ShiftCount = 5'd0;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        check("reset_outputs", {27'd0, busy, done, Zero, Overflow, Illegal, Result},
              {27'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0});
        @(negedge clk);
        check("reset_start_dropped", {62'd0, busy, done}, 64'd0);

        do_op("add_ovf",  4'b0010, 32'h7FFFFFFF, 32'd1, 5'd0, 32'h80000000, 1'b0, 1'b1, 1'b0, 2, bc);
        do_op("sub_zero", 4'b0110, 32'd5, 32'd5, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 2, bc);
        do_op("slt_neg",  4'b0111, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd1, 1'b0, 1'b0, 1'b0, 2, bc);
        do_op("sll4",     4'b1110, 32'd0, 32'h00000003, 5'd4, 32'h00000030, 1'b0, 1'b0, 1'b0, 6, bc);
        check("sll4_busy_cycles", 64'(bc), 64'd5);
        do_op("sll0",     4'b1110, 32'd0, 32'hA5A5A5A5, 5'd0, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, 2, bc);
        do_op("illegal",  4'b1010, 32'h1234, 32'h5678, 5'd3, 32'd0, 1'b1, 1'b0, 1'b1, 2, bc);
        do_op("and",      4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hF000F000, 1'b0, 1'b0, 1'b0, 2, bc);
        do_op("or",       4'b0001, 32'h0F0F0000, 32'h0000F0F0, 5'd0, 32'h0F0FF0F0, 1'b0, 1'b0, 1'b0, 2, bc);
        do_op("nor",      4'b1100, 32'd0, 32'd0, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 2, bc);
        do_op("sub_ovf",  4'b0110, 32'h80000000, 32'd1, 5'd0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 2, bc);
        do_op("add_wrap", 4'b0010, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 2, bc);
        do_op("sub_neg",  4'b0110, 32'd1, 32'd2, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 2, bc);
        do_op("slt_false",4'b0111, 32'd1, 32'hFFFFFFFF, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 2, bc);
        do_op("sll31",    4'b1110, 32'd0, 32'd1, 5'd31, 32'h80000000, 1'b0, 1'b0, 1'b0, 33, bc);
        do_op("sll1",     4'b1110, 32'd0, 32'h80000001, 5'd1, 32'h00000002, 1'b0, 1'b0, 1'b0, 3, bc);

        // sll by 20, with a second start pulsed during SHIFT that must be ignored
        @(negedge clk);
        start = 1'b1; Op = 4'b1110; A = 32'd0; B = 32'h7; ShiftCount = 5'd20;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; Op = 4'b0010; A = 32'd1; B = 32'd1; ShiftCount = 5'd0;
        @(negedge clk);
        start = 1'b0;
        count_done(40, pulses);
        check("restart_done_pulses", 64'(pulses), 64'd1);
        check("restart_res", {32'd0, Result}, {32'd0, 32'h00700000});

        // sll by 20, aborted by reset in the third SHIFT cycle
        @(negedge clk);
        start = 1'b1; Op = 4'b1110; A = 32'd0; B = 32'h7; ShiftCount = 5'd20;
        @(negedge clk);            // EXEC
        start = 1'b0;
        @(negedge clk);            // SHIFT 1
        @(negedge clk);            // SHIFT 2
        @(negedge clk);            // SHIFT 3
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_outputs", {27'd0, busy, done, Zero, Overflow, Illegal, Result},
              {27'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0});
        count_done(30, pulses);
        check("abort_done_pulses", 64'(pulses), 64'd0);
        do_op("after_abort", 4'b0010, 32'd2, 32'd3, 5'd0, 32'd5, 1'b0, 1'b0, 1'b0, 2, bc);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
